paint_scanner: RTL and testbench
================================

# paint_scanner

Frame scan generator and layer compositor driving the shared `paint_x`/`paint_y` bus consumed by every display layer (bird, pipes, background, score). It walks screen coordinates in raster order and collects each layer's `paint_enable`/`paint_color` a fixed pipeline latency later. It resolves layer priority and streams one RGB565 pixel per coordinate to the LCD/framebuffer writer over a valid/ready handshake. Because the layer pipelines cannot stall, the block uses credit-based issue into an output FIFO.

## Interface
- `H_RES`, 480: pixels per line (x range 0..H_RES-1).
- `V_RES`, 800: lines per frame (y range 0..V_RES-1).
- `LAYERS`, 4: number of layer inputs; index 0 has highest priority.
- `LATENCY`, 7: cycles from coordinate presentation to the matching layer output; common to all layers.
- `FIFO_DEPTH`, 16: output FIFO entries; must be ≥ LATENCY+1 (power of two).
- `BG_COLOR`, 16'h0000: colour emitted when no layer is enabled.

- `clk`  in  1  system clock.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `frame_start`  in  1  single-cycle request to scan one frame.
- `paint_x`  out  16 signed  current scan x.
- `paint_y`  out  16 signed  current scan y.
- `layer_enable`  in  LAYERS  per-layer `paint_enable`.
- `layer_color`  in  16*LAYERS  per-layer `paint_color`, layer i at [16i+15:16i].
- `pixel_valid`  out  1  pixel available.
- `pixel_data`  out  16  RGB565 pixel.
- `pixel_last`  out  1  qualifies final pixel of frame.
- `pixel_ready`  in  1  sink accepts pixel when high with `pixel_valid`.
- `frame_busy`  out  1  high from accepted `frame_start` until `frame_done`.
- `frame_done`  out  1  single-cycle pulse after final pixel handshake.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: `frame_start` high → SCAN, `frame_busy`=1, coordinate counter (0,0). `frame_start` in SCAN/DRAIN ignored.
- SCAN: each cycle, issue current coordinate iff `fifo_count + inflight < FIFO_DEPTH`, where a pop in the same cycle counts as freed. Issue: advance x; x==H_RES-1 → x=0, y+1. Non-issue cycle: `paint_x`/`paint_y` hold; result discarded.
- Last coordinate (H_RES-1, V_RES-1) issued → DRAIN.
- Issue flag and a last flag travel down a LATENCY-deep shift register (`inflight` = number of set flags). At the delayed flag, composite: lowest index i with `layer_enable[i]`=1 supplies `layer_color[i]`; none → BG_COLOR. Push {colour, last} into FIFO.
- FIFO head drives `pixel_data`/`pixel_last`; `pixel_valid` = FIFO non-empty. Pop on `pixel_valid && pixel_ready`.
- DRAIN: wait until last pixel popped → `frame_done` for 1 cycle, `frame_busy`=0, IDLE the same cycle.
- Credit rule guarantees the FIFO never overflows. A push to a full FIFO is a design error, flagged by assertion.
- Widths: counters 16-bit; x/y never exceed H_RES-1/V_RES-1; FIFO count log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release): state IDLE, `paint_x`=0, `paint_y`=0, `pixel_valid`=0, `pixel_data`=0, `pixel_last`=0, `frame_busy`=0, `frame_done`=0. Shift register and FIFO cleared.
- `rstn` low mid-frame: frame abandoned, no `frame_done`. In-flight pixels are lost.
- `frame_start` sampled at edge E0 → (0,0) on `paint_x`/`paint_y` after E0. Layer data sampled at E(LATENCY+1), pushed into the FIFO. `pixel_valid` high after E(LATENCY+1).
- `pixel_ready` held high: one pixel per cycle, no bubbles when FIFO_DEPTH ≥ LATENCY+1. `frame_done` occurs LATENCY+2+H_RES·V_RES cycles after E0.
- `pixel_ready` low: issue stalls once credits exhausted. At most FIFO_DEPTH pixels are outstanding. `pixel_data`/`pixel_last` are stable while valid and not ready.
- `frame_start` coincident with `frame_done`: ignored (block still busy that cycle).

## Test plan
- H_RES=4, V_RES=3, LATENCY=7, ready=1, layer model = 7-stage delay of colour=16'h0100·y+x: 12 pixels 0x0000..0x0203 in raster order. `pixel_last` only on the 12th. `frame_done` 21 cycles after E0.
- Priority: layer0 enabled at x==1, layer1 enabled for all pixels, colours A5A5/5A5A → pixel x==1 gives A5A5, others 5A5A. All layers disabled → BG_COLOR.
- Backpressure: `pixel_ready` low for 40 cycles after first valid. No pixel lost or duplicated; FIFO never exceeds 16; `paint_x` frozen after credits are exhausted; output resumes in order.
- Random `pixel_ready` (50%) over a 480×800 frame → 384000 pixels match the reference model, exactly one `pixel_last`, one `frame_done`.
- `frame_start` pulsed again mid-SCAN and on the `frame_done` cycle → ignored; a later `frame_start` in IDLE starts a new frame from (0,0).
- `rstn` asserted mid-frame with `pixel_valid` high → outputs return to reset values immediately (async). A subsequent frame is correct.

Source files
------------

// File: rtl/paint_scanner_if.sv
// Shared paint bus (coordinates out, layer results in) plus the pixel stream
// toward the LCD/framebuffer writer.
interface paint_scanner_if #(
    parameter int LAYERS = 4
);
    logic signed [15:0]     paint_x;
    logic signed [15:0]     paint_y;
    logic [LAYERS-1:0]      layer_enable;
    logic [16*LAYERS-1:0]   layer_color;
    logic                   pixel_valid;
    logic [15:0]            pixel_data;
    logic                   pixel_last;
    logic                   pixel_ready;

    modport master (
        output paint_x, paint_y, pixel_valid, pixel_data, pixel_last,
        input  layer_enable, layer_color, pixel_ready
    );

    modport slave (
        input  paint_x, paint_y, pixel_valid, pixel_data, pixel_last,
        output layer_enable, layer_color, pixel_ready
    );
endinterface

// File: rtl/paint_scanner.sv
// Raster scan generator and layer compositor: issues coordinates on credit,
// composites the delayed layer results and buffers pixels in an output FIFO.
module paint_scanner #(
    parameter int          H_RES      = 480,
    parameter int          V_RES      = 800,
    parameter int          LAYERS     = 4,
    parameter int          LATENCY    = 7,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            frame_start,
    output logic            frame_busy,
    output logic            frame_done,
    paint_scanner_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t             state, state_next;
    logic [15:0]        x_cnt, y_cnt;
    logic [LATENCY-1:0] issue_sr, last_sr;
    logic [IW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [16:0]        fifo_mem [FIFO_DEPTH];
    logic [16:0]        head;
    logic               issue, credit_ok, is_last_coord;
    logic               push, pop, done_next;
    logic [15:0]        comp_color;

    assign is_last_coord = (x_cnt == 16'(H_RES - 1)) && (y_cnt == 16'(V_RES - 1));
    assign push          = issue_sr[LATENCY-1];
    assign pop           = bus.pixel_valid && bus.pixel_ready;
    assign head          = fifo_mem[rd_ptr];

    // A pop in this cycle frees its slot, so issue may reuse it immediately.
    assign credit_ok = (int'(fifo_count) - int'(pop) + int'(inflight)) < FIFO_DEPTH;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start && !frame_done) state_next = SCAN;
            end
            SCAN: begin
                issue = credit_ok;
                if (credit_ok && is_last_coord) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && head[0]) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state == IDLE && state_next == SCAN) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (issue) begin
            if (is_last_coord) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (x_cnt == 16'(H_RES - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_sr <= '0;
            last_sr  <= '0;
            inflight <= '0;
        end else begin
            issue_sr <= {issue_sr[LATENCY-2:0], issue};
            last_sr  <= {last_sr[LATENCY-2:0], issue && is_last_coord};
            inflight <= inflight + IW'(issue) - IW'(push);
        end
    end

    // Lowest-index enabled layer wins; scanning downward lets it overwrite.
    always_comb begin
        comp_color = BG_COLOR;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_enable[i]) comp_color = bus.layer_color[16*i +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {comp_color, last_sr[LATENCY-1]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    assign bus.paint_x     = signed'(x_cnt);
    assign bus.paint_y     = signed'(y_cnt);
    assign bus.pixel_valid = (fifo_count != '0);
    assign bus.pixel_data  = bus.pixel_valid ? head[16:1] : 16'h0000;
    assign bus.pixel_last  = bus.pixel_valid && head[0];
    assign frame_busy      = (state != IDLE);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_paint_scanner.sv
// Bench for paint_scanner: delayed layer model, raster-order reference
// scoreboard and directed frame scenarios on a reduced screen size.
module tb_paint_scanner;
    localparam int          H          = 8;
    localparam int          V          = 4;
    localparam int          N          = H * V;
    localparam int          LAT        = 7;
    localparam int          DEPTH      = 16;
    localparam int          LAYERS     = 4;
    localparam logic [15:0] BG         = 16'h0000;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic frame_start = 1'b0;
    logic frame_busy, frame_done;

    int   total = 0;
    int   bad = 0;
    int   layer_mode = 0;
    int   ready_mode = 0;
    int   got_n = 0;
    int   last_cnt = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    logic [15:0] got_px [64];
    logic signed [15:0] xp [LAT];
    logic signed [15:0] yp [LAT];

    paint_scanner_if #(.LAYERS(LAYERS)) bus();

    paint_scanner #(
        .H_RES(H), .V_RES(V), .LAYERS(LAYERS), .LATENCY(LAT),
        .FIFO_DEPTH(DEPTH), .BG_COLOR(BG)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .frame_start(frame_start),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Layer stimulus as a function of screen position and the active scenario.
    function automatic logic layer_en(int m, int i, int x, int y);
        case (m)
            0: return i == 0;
            1: return (i == 0 && x == 1) || i == 1;
            3: return (i < 3) ? (((x + 2*y + i) % 3) == 0) : (((x ^ y) & 1) == 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] layer_col(int m, int i, int x, int y);
        case (m)
            0: return 16'(256*y + x);
            1: return (i == 0) ? 16'hA5A5 : ((i == 1) ? 16'h5A5A : 16'hFFFF);
            2: return 16'hDEAD;
            default: return 16'(4096*(i+1) + 256*y + x);
        endcase
    endfunction

    function automatic logic [15:0] ref_pixel(int m, int x, int y);
        for (int i = 0; i < LAYERS; i++) begin
            if (layer_en(m, i, x, y)) return layer_col(m, i, x, y);
        end
        return BG;
    endfunction

    // Every layer sees the same LAT-register delay of the paint bus.
    always @(posedge clk) begin
        xp[0] <= bus.paint_x;
        yp[0] <= bus.paint_y;
        for (int k = 1; k < LAT; k++) begin
            xp[k] <= xp[k-1];
            yp[k] <= yp[k-1];
        end
    end

    always_comb begin
        bus.layer_enable = '0;
        bus.layer_color  = '0;
        for (int i = 0; i < LAYERS; i++) begin
            bus.layer_enable[i] = layer_en(layer_mode, i, int'(xp[LAT-1]), int'(yp[LAT-1]));
            bus.layer_color[16*i +: 16] = layer_col(layer_mode, i, int'(xp[LAT-1]), int'(yp[LAT-1]));
        end
    end

    initial begin
        bus.pixel_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.pixel_ready = 1'b1;
                1:       bus.pixel_ready = 1'($urandom_range(0, 1));
                default: bus.pixel_ready = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic build_expected(input int m);
        exp_t e;
        exp_q.delete();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                e.data = ref_pixel(m, x, y);
                e.last = (x == H-1) && (y == V-1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard: checks every accepted pixel, hold stability and frame_done.
    initial begin
        exp_t        e;
        logic        have_prev;
        logic [15:0] prev_data;
        logic        prev_last;
        have_prev = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    checkOutput("hold_valid", 32'(bus.pixel_valid), 32'd1);
                    checkOutput("hold_data", 32'(bus.pixel_data), 32'(prev_data));
                    checkOutput("hold_last", 32'(bus.pixel_last), 32'(prev_last));
                end
                if (bus.pixel_valid && bus.pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_pixel", 32'(bus.pixel_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("pixel_data", 32'(bus.pixel_data), 32'(e.data));
                        checkOutput("pixel_last", 32'(bus.pixel_last), 32'(e.last));
                        if (got_n < 64) got_px[got_n] = bus.pixel_data;
                        got_n++;
                        if (bus.pixel_last) last_cnt++;
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    checkOutput("done_all_popped", 32'(exp_q.size()), 32'd0);
                end
                have_prev = bus.pixel_valid && !bus.pixel_ready;
                prev_data = bus.pixel_data;
                prev_last = bus.pixel_last;
            end
        end
    end

    task automatic applyStimulus(input int m, input int rm, input bit pulse_mid,
                                 input bit pulse_done, output int fv, output int dc);
        int stall;
        int idx_a;
        int idx_b;
        layer_mode = m;
        ready_mode = rm;
        build_expected(m);
        got_n = 0;
        last_cnt = 0;
        done_cnt = 0;
        fv = 0;
        dc = 0;
        stall = 0;
        idx_a = -1;
        @(negedge clk);
        frame_start = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            frame_start = (pulse_mid && c == 5);
            if (c == 2) checkOutput("busy_in_frame", 32'(frame_busy), 32'd1);
            if (fv == 0 && bus.pixel_valid) fv = c;
            if (rm == 2 && fv != 0) begin
                stall++;
                if (stall == 30) idx_a = int'(bus.paint_y) * H + int'(bus.paint_x);
                if (stall == 40) begin
                    idx_b = int'(bus.paint_y) * H + int'(bus.paint_x);
                    checkOutput("stall_issue_index", 32'(idx_b), 32'(DEPTH));
                    checkOutput("stall_frozen", 32'(idx_a), 32'(idx_b));
                    ready_mode = 0;
                end
            end
            if (frame_done) begin
                dc = c;
                break;
            end
        end
        if (dc == 0) checkOutput("frame_timeout", 32'd0, 32'd1);
        if (pulse_done) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            checkOutput("start_on_done_ignored", 32'(frame_busy), 32'd0);
        end
        @(negedge clk);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("pixel_count", 32'(got_n), 32'(N));
        checkOutput("last_count", 32'(last_cnt), 32'd1);
        checkOutput("done_count", 32'(done_cnt), 32'd1);
        checkOutput("idle_busy", 32'(frame_busy), 32'd0);
        checkOutput("idle_x", 32'(bus.paint_x), 32'd0);
        checkOutput("idle_y", 32'(bus.paint_y), 32'd0);
    endtask

    initial begin
        int fv;
        int dc;
        int waited;

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(bus.pixel_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.pixel_data), 32'd0);
        checkOutput("rst_last", 32'(bus.pixel_last), 32'd0);
        checkOutput("rst_busy", 32'(frame_busy), 32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);
        checkOutput("rst_x", 32'(bus.paint_x), 32'd0);
        checkOutput("rst_y", 32'(bus.paint_y), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Colour ramp 0x0100*y+x through layer 0, sink always ready.
        applyStimulus(0, 0, 1'b0, 1'b0, fv, dc);
        checkOutput("first_valid_cycle", 32'(fv), 32'd9);
        checkOutput("done_cycle", 32'(dc), 32'd41);
        checkOutput("ramp_px0", 32'(got_px[0]), 32'h0000);
        checkOutput("ramp_px8", 32'(got_px[8]), 32'h0100);
        checkOutput("ramp_px31", 32'(got_px[31]), 32'h0307);

        // Priority: layer 0 only at x==1 over an always-on layer 1.
        applyStimulus(1, 0, 1'b0, 1'b1, fv, dc);
        checkOutput("prio_px0", 32'(got_px[0]), 32'h5A5A);
        checkOutput("prio_px1", 32'(got_px[1]), 32'hA5A5);
        checkOutput("prio_px9", 32'(got_px[9]), 32'hA5A5);

        // No layer enabled: background only.
        applyStimulus(2, 0, 1'b0, 1'b0, fv, dc);
        checkOutput("bg_px5", 32'(got_px[5]), 32'(BG));

        // Backpressure for 40 cycles plus a start request mid-scan.
        applyStimulus(0, 2, 1'b1, 1'b0, fv, dc);
        checkOutput("stall_px16", 32'(got_px[16]), 32'h0200);

        for (int f = 0; f < 8; f++) applyStimulus(3, 1, 1'b0, 1'b0, fv, dc);

        // Asynchronous reset in the middle of a frame with output pending.
        layer_mode = 0;
        ready_mode = 2;
        build_expected(0);
        done_cnt = 0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        waited = 0;
        while (!bus.pixel_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("pre_reset_valid", 32'(bus.pixel_valid), 32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(bus.pixel_valid), 32'd0);
        checkOutput("async_rst_data", 32'(bus.pixel_data), 32'd0);
        checkOutput("async_rst_busy", 32'(frame_busy), 32'd0);
        checkOutput("async_rst_x", 32'(bus.paint_x), 32'd0);
        checkOutput("async_rst_y", 32'(bus.paint_y), 32'd0);
        ready_mode = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abandoned_no_done", 32'(done_cnt), 32'd0);

        applyStimulus(3, 1, 1'b0, 1'b0, fv, dc);
        applyStimulus(0, 0, 1'b0, 1'b0, fv, dc);
        checkOutput("post_reset_done_cycle", 32'(dc), 32'd41);
        checkOutput("post_reset_px31", 32'(got_px[31]), 32'h0307);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
